// File: rtl/seg_pkg.sv
// Shared types, constants and the hex-to-segment table for the
// seven-segment scan controller.
package seg_pkg;

  localparam int         NUM_DIG = 6;
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [5:0] DIG_OFF = 6'h00;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  // Segment order is g..a in bits [6:0]; lowercase glyphs for b and d.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      4'hF:    hex7 = 7'h71;
      default: hex7 = 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble + decimal point to segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  assign o_seg = {i_dp, hex7(i_nib)};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed seven-segment scanner with per-slot blanking,
// brightness PWM and frame-synchronous (tear-free) display updates.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [23:0] i_data,
  input  logic [5:0]  i_dp,
  input  logic [5:0]  i_dig_en,
  input  logic        i_load,
  input  logic [3:0]  i_bright,
  output logic [7:0]  SEG,
  output logic [5:0]  DIG,
  output logic        o_frame
);

  localparam int            CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [2:0]    DIG_LAST  = 3'(NUM_DIG - 1);

  logic [CW-1:0] r_slot_cnt;
  logic [2:0]    r_dig_idx;
  scan_state_t   r_state;
  logic [3:0]    r_pwm_cnt;
  logic          r_pending;
  logic [23:0]   r_sh_data;
  logic [5:0]    r_sh_dp;
  logic [5:0]    r_sh_en;
  logic [23:0]   r_act_data;
  logic [5:0]    r_act_dp;
  logic [5:0]    r_act_en;

  logic [CW-1:0] w_slot_nxt;
  logic          w_slot_wrap;
  logic          w_boundary;
  scan_state_t   w_state_nxt;
  logic [3:0]    w_nib;
  logic          w_dp;
  logic          w_en;
  logic          w_lit;
  logic [5:0]    w_dig_hot;
  logic [7:0]    w_seg;

  assign w_slot_wrap = (r_slot_cnt == SLOT_LAST);
  assign w_boundary  = w_slot_wrap && (r_dig_idx == DIG_LAST);
  assign w_slot_nxt  = w_slot_wrap ? {CW{1'b0}} : (r_slot_cnt + CW'(1));
  assign w_dig_hot   = 6'b000001 << r_dig_idx;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BLANK: begin
        if (w_slot_nxt >= BLANK_END) begin
          w_state_nxt = ON;
        end else begin
          w_state_nxt = BLANK;
        end
      end
      ON: begin
        if (w_slot_nxt < BLANK_END) begin
          w_state_nxt = BLANK;
        end else begin
          w_state_nxt = ON;
        end
      end
      default: w_state_nxt = BLANK;
    endcase
  end

  // Leftmost digit sits in the top nibble of the frame word.
  always_comb begin
    w_nib = 4'h0;
    w_dp  = 1'b0;
    w_en  = 1'b0;
    case (r_dig_idx)
      3'd0:    begin w_nib = r_act_data[23:20]; w_dp = r_act_dp[0]; w_en = r_act_en[0]; end
      3'd1:    begin w_nib = r_act_data[19:16]; w_dp = r_act_dp[1]; w_en = r_act_en[1]; end
      3'd2:    begin w_nib = r_act_data[15:12]; w_dp = r_act_dp[2]; w_en = r_act_en[2]; end
      3'd3:    begin w_nib = r_act_data[11:8];  w_dp = r_act_dp[3]; w_en = r_act_en[3]; end
      3'd4:    begin w_nib = r_act_data[7:4];   w_dp = r_act_dp[4]; w_en = r_act_en[4]; end
      3'd5:    begin w_nib = r_act_data[3:0];   w_dp = r_act_dp[5]; w_en = r_act_en[5]; end
      default: begin w_nib = 4'h0; w_dp = 1'b0; w_en = 1'b0; end
    endcase
  end

  assign w_lit = (r_state == ON) && w_en && (r_pwm_cnt <= i_bright);

  seg_hex_decode u_dec (
    .i_nib (w_nib),
    .i_dp  (w_dp),
    .o_seg (w_seg)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot_cnt <= {CW{1'b0}};
      r_dig_idx  <= 3'd0;
      r_state    <= BLANK;
      r_pwm_cnt  <= 4'd0;
    end else begin
      r_slot_cnt <= w_slot_nxt;
      r_state    <= w_state_nxt;
      // Held at zero through BLANK so the first ON cycle starts the PWM at 0.
      r_pwm_cnt  <= (r_state == ON) ? (r_pwm_cnt + 4'd1) : 4'd0;
      if (w_slot_wrap) begin
        r_dig_idx <= (r_dig_idx == DIG_LAST) ? 3'd0 : (r_dig_idx + 3'd1);
      end
    end
  end

  // A load on the boundary cycle re-arms pending; the transfer sees the old shadow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending  <= 1'b0;
      r_sh_data  <= 24'h000000;
      r_sh_dp    <= 6'h00;
      r_sh_en    <= 6'h3F;
      r_act_data <= 24'h000000;
      r_act_dp   <= 6'h00;
      r_act_en   <= 6'h3F;
    end else begin
      if (i_load) begin
        r_sh_data <= i_data;
        r_sh_dp   <= i_dp;
        r_sh_en   <= i_dig_en;
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
      if (w_boundary && r_pending) begin
        r_act_data <= r_sh_data;
        r_act_dp   <= r_sh_dp;
        r_act_en   <= r_sh_en;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      SEG     <= SEG_OFF;
      DIG     <= DIG_OFF;
      o_frame <= 1'b0;
    end else begin
      SEG     <= w_lit ? w_seg : SEG_OFF;
      DIG     <= w_lit ? w_dig_hot : DIG_OFF;
      o_frame <= w_boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues per-slot expectations
// for a tagged frame, a monitor summarises each observed frame and compares.
module tb_seg_scan_ctrl;

  localparam int SD    = 32;
  localparam int BC    = 4;
  localparam int FRAME = 6 * SD;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] i_data;
  logic [5:0]  i_dp;
  logic [5:0]  i_dig_en;
  logic        i_load;
  logic [3:0]  i_bright;
  logic [7:0]  SEG;
  logic [5:0]  DIG;
  logic        o_frame;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_data   (i_data),
    .i_dp     (i_dp),
    .i_dig_en (i_dig_en),
    .i_load   (i_load),
    .i_bright (i_bright),
    .SEG      (SEG),
    .DIG      (DIG),
    .o_frame  (o_frame)
  );

  typedef struct {
    int         frame;
    int         slot;
    logic [5:0] dig;
    logic [7:0] seg;
    int         lit;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   fnum   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int lit_count(input logic [3:0] b);
    int n = 0;
    for (int p = 0; p < SD - BC; p++) begin
      if ((p % 16) <= int'(b)) n++;
    end
    return n;
  endfunction

  task automatic push_frame(input int f, input logic [23:0] d, input logic [5:0] dp,
                            input logic [5:0] en, input logic [3:0] b);
    for (int k = 0; k < 6; k++) begin
      exp_t       e;
      logic [3:0] nib;
      nib     = d[(23 - 4 * k) -: 4];
      e.frame = f;
      e.slot  = k;
      e.dig   = en[k] ? (6'b000001 << k) : 6'h00;
      e.seg   = en[k] ? {dp[k], HEX_TAB[nib]} : 8'h00;
      e.lit   = en[k] ? lit_count(b) : 0;
      sb_q.push_back(e);
    end
  endtask

  task automatic do_load(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] en);
    i_data   = d;
    i_dp     = dp;
    i_dig_en = en;
    i_load   = 1'b1;
    @(posedge clk);
    #1;
    i_load   = 1'b0;
  endtask

  // Returns #1 after the second clock edge following the frame pulse.
  task automatic next_frame();
    int f0;
    int to;
    f0 = fnum;
    to = 0;
    do begin
      @(posedge clk);
      #1;
      to++;
    end while (fnum == f0 && to < 400);
    if (fnum == f0) check("frame_wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin : monitor
    bit         synced;
    bit         aborted;
    int         to;
    int         s;
    int         pos;
    exp_t       e;
    logic [5:0] o_dig [6];
    logic [7:0] o_seg [6];
    int         o_lit [6];
    int         o_bad [6];
    synced = 1'b0;
    @(posedge rst_n);
    forever begin
      if (!synced) begin
        to = 0;
        do begin
          @(negedge clk);
          to++;
        end while (!(o_frame === 1'b1 && rst_n === 1'b1) && to < 400);
        if (to >= 400) begin
          check("frame_pulse_timeout", 32'd0, 32'd1);
          continue;
        end
      end
      fnum++;
      synced  = 1'b0;
      aborted = 1'b0;
      for (int k = 0; k < 6; k++) begin
        o_dig[k] = 6'h00;
        o_seg[k] = 8'h00;
        o_lit[k] = 0;
        o_bad[k] = 0;
      end
      for (int i = 1; i <= FRAME; i++) begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        s   = (i - 1) / SD;
        pos = (i - 1) % SD;
        if (DIG != 6'h00) begin
          o_dig[s] |= DIG;
          o_seg[s] |= SEG;
          o_lit[s]++;
          if (pos < BC) o_bad[s]++;
        end else if (SEG != 8'h00) begin
          o_bad[s]++;
        end
        if (i < FRAME && o_frame === 1'b1) o_bad[s]++;
        if (i == FRAME) synced = (o_frame === 1'b1);
      end
      if (aborted) continue;
      check("frame_period", {31'd0, synced}, 32'd1);
      while (sb_q.size() > 0 && sb_q[0].frame < fnum) begin
        e = sb_q.pop_front();
        check("missed_frame", e.frame, fnum);
      end
      while (sb_q.size() > 0 && sb_q[0].frame == fnum) begin
        e = sb_q.pop_front();
        s = e.slot;
        check($sformatf("f%0d_slot%0d_dig", fnum, s), {26'd0, o_dig[s]}, {26'd0, e.dig});
        check($sformatf("f%0d_slot%0d_seg", fnum, s), {24'd0, o_seg[s]}, {24'd0, e.seg});
        check($sformatf("f%0d_slot%0d_lit", fnum, s), o_lit[s], e.lit);
        check($sformatf("f%0d_slot%0d_glitch", fnum, s), o_bad[s], 32'd0);
      end
    end
  end

  initial begin : stimulus
    int to;
    rst_n    = 1'b0;
    i_data   = 24'h000000;
    i_dp     = 6'h00;
    i_dig_en = 6'h00;
    i_load   = 1'b0;
    i_bright = 4'd15;
    #22;
    check("reset_seg", {24'd0, SEG}, 32'h0);
    check("reset_dig", {26'd0, DIG}, 32'h0);
    check("reset_frame", {31'd0, o_frame}, 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // F1: power-on contents, then a mid-frame load that must wait for the boundary.
    next_frame();
    push_frame(fnum, 24'h000000, 6'h00, 6'h3F, 4'd15);
    repeat (50) @(posedge clk);
    #1;
    do_load(24'h12AF08, 6'b100000, 6'h3F);

    // F2: new word visible; load a sparse digit-enable set.
    next_frame();
    push_frame(fnum, 24'h12AF08, 6'b100000, 6'h3F, 4'd15);
    repeat (60) @(posedge clk);
    #1;
    do_load(24'h12AF08, 6'b100000, 6'b101010);

    // F3: dim brightness; load exactly on the closing boundary cycle.
    next_frame();
    i_bright = 4'd3;
    push_frame(fnum, 24'h12AF08, 6'b100000, 6'b101010, 4'd3);
    repeat (190) @(posedge clk);
    #1;
    do_load(24'h345678, 6'h00, 6'h3F);

    // F4: boundary load not yet visible.
    next_frame();
    i_bright = 4'd15;
    push_frame(fnum, 24'h12AF08, 6'b100000, 6'b101010, 4'd15);

    // F5: boundary load now visible; two loads, the second must win.
    next_frame();
    push_frame(fnum, 24'h345678, 6'h00, 6'h3F, 4'd15);
    repeat (20) @(posedge clk);
    #1;
    do_load(24'hFFFFFF, 6'h3F, 6'h3F);
    repeat (80) @(posedge clk);
    #1;
    do_load(24'h9ABCDE, 6'b010101, 6'h3F);

    next_frame();
    push_frame(fnum, 24'h9ABCDE, 6'b010101, 6'h3F, 4'd15);

    // F7: asynchronous reset while digit 3 is lit.
    next_frame();
    repeat (106) @(posedge clk);
    @(negedge clk);
    check("pre_reset_dig", {26'd0, DIG}, 32'h08);
    check("pre_reset_seg", {24'd0, SEG}, 32'h39);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_dig", {26'd0, DIG}, 32'h0);
    check("async_reset_seg", {24'd0, SEG}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= BC; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_blank%0d", c), {26'd0, DIG}, 32'h0);
    end
    @(posedge clk);
    #1;
    check("post_reset_first_dig", {26'd0, DIG}, 32'h01);
    check("post_reset_first_seg", {24'd0, SEG}, 32'h3F);

    next_frame();
    push_frame(fnum, 24'h000000, 6'h00, 6'h3F, 4'd15);

    to = 0;
    while (sb_q.size() > 0 && to < 400) begin
      @(posedge clk);
      to++;
    end
    check("scoreboard_drain", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
